exception_ctrl: RTL and testbench

Exception and return controller sitting directly downstream of the main decoder. It consumes the decode-stage `ERet`/`EStatus` pair plus an external interrupt line. It captures the faulting PC and cause into `ELR`/`ESR`, flushes the pipeline and redirects fetch to the exception vector. On `ERET` it redirects back to `ELR`, and it serves `ELR`/`ESR` to `MRS` through a read port.

---
 rtl/exception_ctrl_pkg.sv | 36 +++
 rtl/exception_ctrl_if.sv | 48 ++++
 rtl/exception_ctrl_flush_counter.sv | 29 ++
 rtl/exception_ctrl.sv | 114 +++++++++++
 tb/tb_exception_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the exception/return controller.
// Imported by the interface, the flush counter and the controller top.
package exception_ctrl_pkg;

  typedef enum logic [1:0] {
    USER,
    TAKE,
    HANDLER,
    RETURN
  } exc_state_t;

  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_UNDEF  = 4'b0001;
  localparam logic [3:0] ESR_IRQ    = 4'b0010;
  localparam logic [3:0] ESR_BADRET = 4'b0011;

  localparam logic MRS_ELR = 1'b0;
  localparam logic MRS_ESR = 1'b1;

  localparam int CNT_W = $clog2(8);

  // Sync cause first, then illegal return, then the interrupt line.
  function automatic logic [3:0] pick_cause(
    input logic [3:0] estatus,
    input logic       eret,
    input logic       irq
  );
    logic [3:0] c;
    c = ESR_NONE;
    if (estatus != ESR_NONE) c = estatus;
    else if (eret)           c = ESR_BADRET;
    else if (irq)            c = ESR_IRQ;
    return c;
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Decode-side bundle between the decoder/fetch and the
// exception controller.
interface exception_ctrl_if #(
  parameter int N = 64
);
  logic         valid_d;
  logic [3:0]   estatus_d;
  logic         eret_d;
  logic [N-1:0] pc_d;
  logic         ext_irq;
  logic         mrs_sel;
  logic [N-1:0] mrs_data;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic         flush;
  logic         in_handler;
  logic         irq_ack;

  modport master (
    output valid_d,
    output estatus_d,
    output eret_d,
    output pc_d,
    output ext_irq,
    output mrs_sel,
    input  mrs_data,
    input  redirect,
    input  redirect_pc,
    input  flush,
    input  in_handler,
    input  irq_ack
  );

  modport slave (
    input  valid_d,
    input  estatus_d,
    input  eret_d,
    input  pc_d,
    input  ext_irq,
    input  mrs_sel,
    output mrs_data,
    output redirect,
    output redirect_pc,
    output flush,
    output in_handler,
    output irq_ack
  );
endinterface

// File: rtl/exception_ctrl_flush_counter.sv
// Loadable down-counter that holds the pipeline squash window
// open after each redirect.
module flush_counter
  import exception_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/exception_ctrl.sv
// Exception entry/return controller: captures ELR/ESR, redirects
// fetch to the vector or back to ELR and squashes the front end.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int           N            = 64,
  parameter logic [N-1:0] VECTOR       = 64'h0000_0000_0000_00D8,
  parameter int           FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  exception_ctrl_if.slave bus
);

  // TAKE/RETURN already flush for one cycle, the counter covers the rest.
  localparam logic [CNT_W-1:0] FLUSH_LOAD =
    CNT_W'(FLUSH_CYCLES - 1);

  exc_state_t   state;
  exc_state_t   state_nx;
  logic [N-1:0] elr;
  logic [3:0]   esr;
  logic [3:0]   cause;
  logic         busy;
  logic         take;
  logic         ret;
  logic         cnt_load;

  assign cause = pick_cause(bus.estatus_d,
                            bus.eret_d,
                            bus.ext_irq);

  assign take = (state == USER) && bus.valid_d &&
                !busy && (cause != ESR_NONE);

  assign ret  = (state == HANDLER) && bus.valid_d &&
                bus.eret_d;

  assign cnt_load = (state == TAKE) || (state == RETURN);

  flush_counter #(
    .W (CNT_W)
  ) u_flush_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (FLUSH_LOAD),
    .busy     (busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= USER;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      USER:    if (take) state_nx = TAKE;
      TAKE:    state_nx = HANDLER;
      HANDLER: if (ret) state_nx = RETURN;
      RETURN:  state_nx = USER;
      default: state_nx = USER;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elr <= '0;
      esr <= ESR_NONE;
    end else if (take) begin
      elr <= bus.pc_d;
      esr <= cause;
    end else if (state == RETURN) begin
      esr <= ESR_NONE;
    end
  end

  always_comb begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.in_handler  = 1'b0;
    bus.irq_ack     = 1'b0;
    bus.flush       = busy;
    unique case (state)
      USER: begin
      end
      TAKE: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = VECTOR;
        bus.in_handler  = 1'b1;
        bus.irq_ack     = (esr == ESR_IRQ);
        bus.flush       = 1'b1;
      end
      HANDLER: begin
        bus.in_handler  = 1'b1;
      end
      RETURN: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = elr;
        bus.flush       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.mrs_data = (bus.mrs_sel == MRS_ESR) ?
                        {{(N-4){1'b0}}, esr} : elr;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed vector table, reset corners
// and a randomized run against a cycle-indexed event model.
module tb_exception_ctrl;

  localparam int          N   = 64;
  localparam logic [63:0] VEC = 64'hD8;
  localparam int          FC  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exception_ctrl_if #(.N(N)) bus ();

  exception_ctrl #(
    .N            (N),
    .VECTOR       (VEC),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [3:0]  est;
    logic        er;
    logic [63:0] pc;
    logic        irq;
    logic        sel;
    logic        rd;
    logic [63:0] rpc;
    logic        fl;
    logic        ih;
    logic        ack;
    logic [63:0] mrs;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic v, input logic [3:0] est,
    input logic er, input logic [63:0] pc,
    input logic irq, input logic sel,
    input logic rd, input logic [63:0] rpc,
    input logic fl, input logic ih,
    input logic ack, input logic [63:0] mrs
  );
    vec_t r;
    r.v = v; r.est = est; r.er = er; r.pc = pc;
    r.irq = irq; r.sel = sel; r.rd = rd; r.rpc = rpc;
    r.fl = fl; r.ih = ih; r.ack = ack; r.mrs = mrs;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic rd, input logic [63:0] rpc,
                         input logic fl, input logic ih,
                         input logic ack, input logic [63:0] mrs);
    chk({tag, " redirect"},    64'(bus.redirect),   64'(rd));
    chk({tag, " redirect_pc"}, bus.redirect_pc,     rpc);
    chk({tag, " flush"},       64'(bus.flush),      64'(fl));
    chk({tag, " in_handler"},  64'(bus.in_handler), 64'(ih));
    chk({tag, " irq_ack"},     64'(bus.irq_ack),    64'(ack));
    chk({tag, " mrs_data"},    bus.mrs_data,        mrs);
  endtask

  task automatic drive(input logic v, input logic [3:0] est,
                       input logic er, input logic [63:0] pc,
                       input logic irq, input logic sel);
    bus.valid_d   = v;
    bus.estatus_d = est;
    bus.eret_d    = er;
    bus.pc_d      = pc;
    bus.ext_irq   = irq;
    bus.mrs_sel   = sel;
  endtask

  // Event model: absolute cycle numbers for redirects and flush windows.
  int          c;
  logic        m_hmode;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;
  int          rd_cyc, fl_s, fl_e, esr_clr;
  logic [63:0] rd_pc;
  logic        rd_irq;

  task automatic model_reset();
    c = 0; m_hmode = 0; m_elr = '0; m_esr = '0;
    rd_cyc = -1; fl_s = 0; fl_e = -1; esr_clr = -1;
    rd_pc = '0; rd_irq = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] est,
                            input logic er, input logic [63:0] pc,
                            input logic irq);
    logic [3:0] cause;
    logic       fl_now;
    fl_now = (c >= fl_s) && (c <= fl_e);
    cause = (est != 0) ? est : er ? 4'd3 : irq ? 4'd2 : 4'd0;
    if (c + 1 == esr_clr) m_esr = '0;
    if (!m_hmode && !fl_now && v && cause != 0) begin
      m_elr = pc; m_esr = cause;
      rd_cyc = c + 1; rd_pc = VEC; rd_irq = (cause == 4'd2);
      fl_s = c + 1; fl_e = c + FC; m_hmode = 1;
    end else if (m_hmode && c != rd_cyc && v && er) begin
      rd_cyc = c + 1; rd_pc = m_elr; rd_irq = 0;
      fl_s = c + 1; fl_e = c + FC; m_hmode = 0;
      esr_clr = c + 2;
    end
    c++;
  endtask

  initial begin
    logic        v, er, irq, sel, rd;
    logic [3:0]  est;
    logic [63:0] pc, mrs;

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'($urandom), 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      #1 chk_out("in_reset", 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1'(i));
      #1 chk_out("post_reset_idle", 0, 0, 0, 0, 0, 0);
    end

    //                v est er pc      irq sel rd rpc     fl ih ak mrs
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0, 0, 64'h0,  0, 0, 0, 64'h0));
    tbl.push_back(mk(1, 1, 0, 64'h40, 0, 0, 0, 64'h0,  0, 0, 0, 64'h0));
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0, 1, VEC,    1, 1, 0, 64'h40));
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 1, 0, 64'h0,  1, 1, 0, 64'h1));
    tbl.push_back(mk(1, 0, 0, 64'h0,  1, 1, 0, 64'h0,  0, 1, 0, 64'h1));
    tbl.push_back(mk(1, 1, 0, 64'h0,  1, 1, 0, 64'h0,  0, 1, 0, 64'h1));
    tbl.push_back(mk(1, 0, 1, 64'h99, 0, 1, 0, 64'h0,  0, 1, 0, 64'h1));
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 1, 1, 64'h40, 1, 0, 0, 64'h1));
    tbl.push_back(mk(1, 1, 0, 64'h50, 0, 1, 0, 64'h0,  1, 0, 0, 64'h0));
    tbl.push_back(mk(1, 0, 0, 64'h80, 1, 0, 0, 64'h0,  0, 0, 0, 64'h40));
    tbl.push_back(mk(1, 0, 0, 64'h84, 1, 1, 1, VEC,    1, 1, 1, 64'h2));
    tbl.push_back(mk(1, 0, 0, 64'h88, 1, 0, 0, 64'h0,  1, 1, 0, 64'h80));
    tbl.push_back(mk(1, 0, 0, 64'h8C, 1, 1, 0, 64'h0,  0, 1, 0, 64'h2));
    tbl.push_back(mk(1, 0, 1, 64'h90, 0, 1, 0, 64'h0,  0, 1, 0, 64'h2));
    tbl.push_back(mk(1, 0, 0, 64'h0,  1, 1, 1, 64'h80, 1, 0, 0, 64'h2));
    tbl.push_back(mk(1, 0, 1, 64'h10, 0, 1, 0, 64'h0,  1, 0, 0, 64'h0));
    tbl.push_back(mk(1, 0, 1, 64'h10, 0, 0, 0, 64'h0,  0, 0, 0, 64'h80));
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 1, 1, VEC,    1, 1, 0, 64'h3));
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0, 0, 64'h0,  1, 1, 0, 64'h10));
    tbl.push_back(mk(1, 5, 0, 64'h20, 1, 1, 0, 64'h0,  0, 1, 0, 64'h3));
    tbl.push_back(mk(1, 0, 1, 64'h24, 0, 1, 0, 64'h0,  0, 1, 0, 64'h3));
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0, 1, 64'h10, 1, 0, 0, 64'h10));
    tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0, 0, 64'h0,  1, 0, 0, 64'h10));
    tbl.push_back(mk(0, 1, 1, 64'h60, 1, 1, 0, 64'h0,  0, 0, 0, 64'h0));
    tbl.push_back(mk(1, 1, 0, 64'h30, 1, 1, 0, 64'h0,  0, 0, 0, 64'h0));
    tbl.push_back(mk(0, 0, 0, 64'h0,  1, 1, 1, VEC,    1, 1, 0, 64'h1));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].est, tbl[i].er,
            tbl[i].pc, tbl[i].irq, tbl[i].sel);
      #1 chk_out($sformatf("row%0d", i), tbl[i].rd, tbl[i].rpc,
                 tbl[i].fl, tbl[i].ih, tbl[i].ack, tbl[i].mrs);
    end

    // Last row leaves the controller in its vector-redirect cycle.
    reset = 1'b0;
    #1 chk_out("reset_in_take", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1'(i));
      #1 chk_out("after_take_reset", 0, 0, 0, 0, 0, 0);
    end

    reset = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      v   = ($urandom_range(0, 9) < 8);
      est = ($urandom_range(0, 9) == 0) ?
            4'($urandom_range(1, 15)) : 4'd0;
      er  = ($urandom_range(0, 5) == 0);
      irq = ($urandom_range(0, 6) == 0);
      sel = 1'($urandom);
      pc  = {$urandom, $urandom};
      drive(v, est, er, pc, irq, sel);
      rd  = (c == rd_cyc);
      mrs = sel ? {60'd0, m_esr} : m_elr;
      #1 chk_out("rand", rd, rd ? rd_pc : 64'd0,
                 (c >= fl_s) && (c <= fl_e), m_hmode,
                 rd && rd_irq, mrs);
      @(posedge clk);
      model_step(v, est, er, pc, irq);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
